tinyqv_load_store_unit: RTL and testbench

- Sits directly downstream of the TinyQV nibble-serial core and bridges it to a word-wide request/acknowledge memory bus.
- Store path: captures the 8-nibble store data stream, then issues one bus write when the core presents the address.
- Load path: issues one bus read, then replays the returned word to the core as 8 nibbles, aligned to the core's sub-cycle counter, with `load_data_ready`.

---
 rtl/tinyqv_load_store_unit.sv | 107 ++++++++++
 tb/tb_tinyqv_load_store_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/tinyqv_load_store_unit.sv
// Bridges the TinyQV nibble-serial core to a word-wide req/ack memory bus:
// assembles store words, issues one bus access, and replays load data as nibbles.
module tinyqv_load_store_unit #(
  parameter int ADDR_BITS = 28
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           counter,
  input  logic                 is_load,
  input  logic                 is_store,
  input  logic [2:0]           mem_op,
  input  logic                 address_ready,
  input  logic [ADDR_BITS-1:0] addr_in,
  input  logic [3:0]           store_nibble,
  output logic [3:0]           load_nibble,
  output logic                 load_data_ready,
  output logic                 busy,
  output logic                 bus_req,
  output logic                 bus_we,
  output logic [1:0]           bus_size,
  output logic [ADDR_BITS-1:0] bus_addr,
  output logic [31:0]          bus_wdata,
  input  logic                 bus_ack,
  input  logic [31:0]          bus_rdata,
  output logic                 proto_err
);

  typedef enum logic [1:0] {IDLE, REQ, ALIGN, DELIVER} state_t;

  state_t      state, state_nxt;
  logic [31:0] sd;
  logic [31:0] rd;
  logic [31:0] store_word;
  logic        accept;
  logic        load_ack;
  logic        last_nibble;

  // mem_op[2] selects sign extension, which the core performs itself.
  logic unused_sign;
  assign unused_sign = mem_op[2];

  function automatic logic [3:0] nibble_sel(input logic [31:0] w, input logic [2:0] idx);
    nibble_sel = w[{idx, 2'b00} +: 4];
  endfunction

  assign store_word  = {store_nibble, sd[31:4]};
  assign accept      = (state == IDLE) && address_ready && (is_load || is_store);
  assign load_ack    = (state == REQ) && bus_ack && !bus_we;
  assign last_nibble = (counter == 3'd7);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = REQ;
      end
      REQ: begin
        if (bus_ack) begin
          if (bus_we)           state_nxt = IDLE;
          else if (last_nibble) state_nxt = DELIVER;
          else                  state_nxt = ALIGN;
        end
      end
      ALIGN: begin
        if (last_nibble) state_nxt = DELIVER;
      end
      DELIVER: begin
        if (last_nibble) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Request fields are latched once at acceptance and held until the bus acks.
  always_ff @(posedge clk) begin
    if (rst) begin
      sd        <= 32'h0;
      rd        <= 32'h0;
      bus_addr  <= '0;
      bus_size  <= 2'b00;
      bus_we    <= 1'b0;
      bus_wdata <= 32'h0;
      proto_err <= 1'b0;
    end else begin
      if (is_store) sd <= store_word;
      if (accept) begin
        bus_addr <= addr_in;
        bus_size <= mem_op[1:0];
        bus_we   <= is_store;
        if (is_store) bus_wdata <= store_word;
      end
      if (load_ack) rd <= bus_rdata;
      if (address_ready && (state != IDLE)) proto_err <= 1'b1;
    end
  end

  assign bus_req         = (state == REQ);
  assign busy            = (state != IDLE) || accept;
  assign load_data_ready = (state == DELIVER);
  assign load_nibble     = load_data_ready ? nibble_sel(rd, counter) : 4'h0;

endmodule

// File: tb/tb_tinyqv_load_store_unit.sv
// Randomised bench for tinyqv_load_store_unit against a transaction-level timing model.
module tb_tinyqv_load_store_unit;
  localparam int ADDR_BITS = 28;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [2:0]           counter;
  logic                 is_load, is_store;
  logic [2:0]           mem_op;
  logic                 address_ready;
  logic [ADDR_BITS-1:0] addr_in;
  logic [3:0]           store_nibble;
  logic [3:0]           load_nibble;
  logic                 load_data_ready, busy;
  logic                 bus_req, bus_we;
  logic [1:0]           bus_size;
  logic [ADDR_BITS-1:0] bus_addr;
  logic [31:0]          bus_wdata;
  logic                 bus_ack;
  logic [31:0]          bus_rdata;
  logic                 proto_err;

  tinyqv_load_store_unit #(.ADDR_BITS(ADDR_BITS)) dut (
    .clk(clk), .rst(rst), .counter(counter), .is_load(is_load), .is_store(is_store),
    .mem_op(mem_op), .address_ready(address_ready), .addr_in(addr_in),
    .store_nibble(store_nibble), .load_nibble(load_nibble),
    .load_data_ready(load_data_ready), .busy(busy), .bus_req(bus_req), .bus_we(bus_we),
    .bus_size(bus_size), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic        pe_exp = 1'b0;
  logic [31:0] wdata_exp = 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc_begin();
    @(posedge clk);
    #1;
    counter       = counter + 3'd1;
    rst           = 1'b0;
    address_ready = 1'b0;
    is_load       = 1'b0;
    is_store      = 1'b0;
    bus_ack       = 1'b0;
    bus_rdata     = $urandom;
    addr_in       = ADDR_BITS'($urandom);
    store_nibble  = 4'($urandom);
    mem_op        = 3'($urandom);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_req"},   32'(bus_req), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_ldr"},   32'(load_data_ready), 32'd0);
    chk({tag, "_perr"},  32'(proto_err), 32'(pe_exp));
  endtask

  function automatic logic [31:0] size_mask(input logic [31:0] d, input logic [1:0] sz);
    if (sz == 2'd0)      return d & 32'h0000_00FF;
    else if (sz == 2'd1) return d & 32'h0000_FFFF;
    else                 return d;
  endfunction

  // One transaction: address pass, then ack on REQ clock ack_d (1 = first REQ clock).
  // pe_t / rst_t (0 = none) inject a stray address_ready or a reset on that clock.
  task automatic run_txn(input bit is_st, input logic [ADDR_BITS-1:0] a, input logic [1:0] sz,
                         input logic [31:0] d, input int ack_d, input int pe_t, input int rst_t);
    logic [31:0] wexp;
    int c, ds, last;
    bit ldr_e;
    wexp = size_mask(d, sz);
    c    = (ack_d - 1) % 8;
    ds   = ack_d + 8 - c;
    last = is_st ? ack_d + 1 : ds + 8;
    while (counter != 3'd7) begin
      cyc_begin();
      @(negedge clk);
    end
    for (int k = 0; k < 8; k++) begin
      cyc_begin();
      mem_op = {1'($urandom), sz};
      if (is_st) begin
        is_store     = 1'b1;
        store_nibble = wexp[4*k +: 4];
      end else begin
        is_load = 1'b1;
      end
      if (k == 7) begin
        address_ready = 1'b1;
        addr_in       = a;
      end
      @(negedge clk);
      chk("addr_pass_busy", 32'(busy), (k == 7) ? 32'd1 : 32'd0);
      chk("addr_pass_req",  32'(bus_req), 32'd0);
    end
    if (is_st) wdata_exp = wexp;
    for (int t = 1; t <= last; t++) begin
      cyc_begin();
      if (is_st) is_store = 1'b1;
      else       is_load  = (t < ds);
      if (t == ack_d) begin
        bus_ack = 1'b1;
        if (!is_st) bus_rdata = d;
      end else if (t > ack_d) begin
        bus_ack = 1'($urandom);
      end
      if (t == pe_t) begin
        address_ready = 1'b1;
        is_load       = 1'b1;
        addr_in       = ~a;
      end
      if (t == rst_t) rst = 1'b1;
      @(negedge clk);
      if (rst_t > 0 && t == rst_t + 1) begin
        pe_exp    = 1'b0;
        wdata_exp = 32'h0;
        chk_idle("rst");
        chk("rst_nib",   32'(load_nibble), 32'd0);
        chk("rst_addr",  32'(bus_addr), 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_size",  32'(bus_size), 32'd0);
        chk("rst_we",    32'(bus_we), 32'd0);
        return;
      end
      if (pe_t > 0 && t == pe_t + 1) pe_exp = 1'b1;
      if (t == last) begin
        chk_idle("done");
      end else begin
        ldr_e = !is_st && (t >= ds) && (t <= ds + 7);
        chk("req",  32'(bus_req), (t <= ack_d) ? 32'd1 : 32'd0);
        chk("busy", 32'(busy), 32'd1);
        chk("ldr",  32'(load_data_ready), 32'(ldr_e));
        chk("perr", 32'(proto_err), 32'(pe_exp));
        if (ldr_e) chk("nibble", 32'(load_nibble), 32'(d[4*(t-ds) +: 4]));
        if (t <= ack_d) begin
          chk("bus_addr",  32'(bus_addr), 32'(a));
          chk("bus_we",    32'(bus_we), 32'(is_st));
          chk("bus_size",  32'(bus_size), 32'(sz));
          chk("bus_wdata", bus_wdata, wdata_exp);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; counter = 3'd0; is_load = 1'b0; is_store = 1'b0; mem_op = 3'd0;
    address_ready = 1'b0; addr_in = '0; store_nibble = 4'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    cyc_begin(); rst = 1'b1;
    cyc_begin();
    @(negedge clk);
    chk_idle("reset");
    chk("reset_addr",  32'(bus_addr), 32'd0);
    chk("reset_wdata", bus_wdata, 32'd0);
    chk("reset_nib",   32'(load_nibble), 32'd0);

    run_txn(1'b1, 28'h0001234, 2'd2, 32'h12345678, 3, 0, 0);
    chk("store_word_wdata", bus_wdata, 32'h12345678);
    run_txn(1'b0, 28'h0000100, 2'd2, 32'hDEADBEEF, 1, 0, 0);
    run_txn(1'b0, 28'h0000200, 2'd2, 32'hCAFEF00D, 8, 0, 0);
    run_txn(1'b0, 28'h0000300, 2'd1, 32'h89ABCDEF, 21, 0, 0);
    run_txn(1'b1, 28'h0ABCDEF, 2'd0, 32'hFFFFFFA5, 21, 0, 0);
    run_txn(1'b0, 28'h0000400, 2'd2, 32'h0F1E2D3C, 5, 2, 0);
    run_txn(1'b1, 28'h0000500, 2'd2, 32'h55AA33CC, 4, 4, 0);
    run_txn(1'b0, 28'h0000600, 2'd2, 32'h11223344, 10, 0, 3);
    run_txn(1'b0, 28'h0000700, 2'd2, 32'h99887766, 1, 0, 12);
    run_txn(1'b1, 28'h0000800, 2'd1, 32'h0000BEEF, 2, 0, 5);

    // An address_ready with neither load nor store must be ignored.
    cyc_begin();
    address_ready = 1'b1;
    @(negedge clk);
    chk("ignored_busy", 32'(busy), 32'd0);
    cyc_begin();
    @(negedge clk);
    chk_idle("ignored");

    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom), ADDR_BITS'($urandom), 2'($urandom_range(0, 2)), $urandom,
              $urandom_range(1, 24), 0, 0);
      for (int j = 0; j < int'($urandom_range(0, 5)); j++) begin
        cyc_begin();
        @(negedge clk);
        chk_idle("gap");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
